// File: rtl/fsm_run_gen.sv
// fsm_run_gen: run-length line generator.
// Accepts a request with a run length, drives x_out high for exactly that many
// cycles, then holds it low for GAP guard cycles before it will take another
// request. A completion pulse (done) marks the first guard cycle; aborted
// accompanies it when the run was cut short by abort.
// Optional build macro FSM_RUN_GEN_BACK_TO_BACK_EN: when defined, req_ready is
// also raised in the last guard cycle so a new run can follow with no idle cycle.
module fsm_run_gen #(
    parameter int LEN_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    input  logic             abort,
    output logic             x_out,
    output logic             done,
    output logic             aborted
);

    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [LEN_W-1:0] run_cnt_r;   // high cycles remaining, including the current one
    logic [LEN_W-1:0] run_cnt_s;
    logic [GAP_W-1:0] gap_cnt_r;   // guard cycles remaining, including the current one
    logic [GAP_W-1:0] gap_cnt_s;
    logic             start_s;
    logic             x_out_s;
    logic             req_ready_s;
    logic             done_s;
    logic             aborted_s;

    // Next-state, counter and next-output logic; outputs are computed for the
    // upcoming cycle so they can be registered without adding latency.
    always_comb begin
        state_s     = state_r;
        run_cnt_s   = run_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        done_s      = 1'b0;
        aborted_s   = 1'b0;
        x_out_s     = 1'b0;
        req_ready_s = 1'b0;

        // req_ready is only ever high in a state that may accept, so the
        // handshake alone decides acceptance.
        start_s = req_valid && req_ready;

        if (start_s) begin
            if (req_len != LEN_ZERO) begin
                state_s   = ST_HIGH;
                run_cnt_s = req_len;
            end else begin
                // Zero-length run: skip straight to the guard gap and complete.
                state_s   = ST_GAP;
                gap_cnt_s = GAP_LOAD;
                done_s    = 1'b1;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_HIGH: begin
                    if (abort) begin
                        state_s   = ST_GAP;
                        gap_cnt_s = GAP_LOAD;
                        done_s    = 1'b1;
                        aborted_s = 1'b1;
                    end else if (run_cnt_r == LEN_ONE) begin
                        state_s   = ST_GAP;
                        gap_cnt_s = GAP_LOAD;
                        done_s    = 1'b1;
                    end else begin
                        run_cnt_s = run_cnt_r - LEN_ONE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_ONE) begin
                        state_s = ST_IDLE;
                    end else begin
                        gap_cnt_s = gap_cnt_r - GAP_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        x_out_s = (state_s == ST_HIGH);
`ifdef FSM_RUN_GEN_BACK_TO_BACK_EN
        req_ready_s = (state_s == ST_IDLE) ||
                      ((state_s == ST_GAP) && (gap_cnt_s == GAP_ONE));
`else
        req_ready_s = (state_s == ST_IDLE);
`endif
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            run_cnt_r <= LEN_ZERO;
            gap_cnt_r <= {GAP_W{1'b0}};
            x_out     <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state_r   <= state_s;
            run_cnt_r <= run_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            x_out     <= x_out_s;
            req_ready <= req_ready_s;
            done      <= done_s;
            aborted   <= aborted_s;
        end
    end

endmodule

// File: doc/fsm_run_gen.md
Name: fsm_run_gen

Overview:
- Transmit-side counterpart to the run-length detector FSM (fsm3cycles_high).
- On a request, drives its line output high for exactly a requested number of consecutive cycles, then holds it low for a fixed guard gap.
- Sits upstream of the detector: x_out connects to the detector's x input.
- Provides a ready/valid request handshake, a completion pulse and an abort path.

Parameters:
- LEN_W, 4: width of req_len; maximum run length is 2^LEN_W-1 cycles.
- GAP, 2: number of low guard cycles after every run; must be >=1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_len  input  LEN_W  requested high-run length in cycles; sampled only on acceptance.
- req_ready  output  1  block can accept a request.
- abort  input  1  terminate the current high run early.
- x_out  output  1  generated line; registered.
- done  output  1  one-cycle pulse at run completion.
- aborted  output  1  one-cycle pulse, coincident with done, when the run was aborted.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - All outputs are registered.
- Reset values: state=IDLE, x_out=0, done=0, aborted=0, req_ready=1 from the first cycle after reset.
- States: IDLE, HIGH, GAP.
  - Run counter is LEN_W bits.
  - Gap counter is $clog2(GAP+1) bits.
- IDLE:
  - req_ready=1, x_out=0.
  - Accept when req_valid&&req_ready at an edge (cycle T); capture req_len.
  - If len>=1: go to HIGH.
  - If len==0: go to GAP; x_out never rises; done pulses in cycle T+1.
- HIGH:
  - x_out=1 in cycles T+1 .. T+len, exactly len cycles.
  - req_ready=0; req_len and req_valid are ignored.
  - After the len-th high cycle, go to GAP.
- GAP:
  - x_out=0 for exactly GAP cycles, T+len+1 .. T+len+GAP.
  - done=1 in the first GAP cycle only.
  - Return to IDLE; req_ready=1 at T+len+GAP+1.
- Abort:
  - Sampled only in HIGH.
  - If abort=1 at the edge ending a HIGH cycle: x_out=0 next cycle, enter GAP with a full GAP count, done=1 and aborted=1 in that first GAP cycle.
  - Abort coinciding with the last HIGH cycle still counts as an abort (aborted=1).
  - Abort in IDLE or GAP is ignored.
- Counting: no wrap. The maximum length 2^LEN_W-1 produces exactly that many high cycles.
- Reset mid-run (HIGH or GAP): next cycle x_out=0, state IDLE, no done pulse, req_ready=1.
- Reset has priority over abort and over request acceptance.

Optional Feature:
- Macro: FSM_RUN_GEN_BACK_TO_BACK_EN.
- Defined:
  - req_ready=1 also in the last GAP cycle (T+len+GAP).
  - A request accepted there starts its high run at T+len+GAP+1 with no IDLE cycle.
  - The low gap between runs is exactly GAP cycles.
- Undefined:
  - req_ready=1 only in IDLE.
  - Minimum low time between consecutive runs is GAP+1 cycles.

Test Plan:
- Reset then len=3 accepted at T: x_out=1 at T+1..T+3; 0 at T+4,T+5; done=1 at T+4 only; req_ready=1 at T+6.
- len=0 accepted at T: x_out stays 0; done=1 at T+1; aborted=0; req_ready=1 at T+3 (GAP=2).
- len=15 accepted: x_out high for exactly 15 cycles; req_valid held high with new req_len throughout is ignored until IDLE.
- len=8, abort=1 during the 3rd high cycle: x_out high for 3 cycles total, then 2 low; done=aborted=1 in the first low cycle.
- rst=1 during the 2nd high cycle of len=5: x_out=0 next cycle, no done, req_ready=1; a new len=2 run then completes normally.
- Back-to-back requests len=2, len=2 with req_valid held high:
  - macro off: 3 low cycles between runs;
  - macro on: exactly 2 low cycles;
  - fsm3cycles_high's y never asserts for len<3 and asserts for a len=3 run.
